// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave front end: pad idle levels and the
// default synchronizer depth / glitch-filter length.
package spi_pkg;

    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_WAIT_CYCLES = 3;

endpackage

// File: rtl/spi_input_channel.sv
// One pad channel: flop-chain synchronizer, consecutive-sample glitch filter
// and registered single-cycle rise/fall flags on the filtered level.
module spi_input_channel
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic cond,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W   = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchronize the pad, then only accept a new level after WAIT_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            cond   <= RESET_VAL;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync == cond) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cond <= sync;
                cnt  <= '0;
                rise <= sync;
                fall <= ~sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_input_conditioner.sv
// SPI slave input conditioner: three filtered pad channels plus chip-select
// gating of the SCLK edge strobes so the slave logic runs on clk with enables.
module spi_input_conditioner
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_raw,
    input  logic cs_raw,
    input  logic mosi_raw,
    output logic sclk_cond,
    output logic cs_cond,
    output logic mosi_cond,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic sclk_rise_flag;
    logic sclk_fall_flag;
    logic mosi_rise_unused;
    logic mosi_fall_unused;
    logic frame_active;

    spi_input_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .WAIT_CYCLES (WAIT_CYCLES),
        .RESET_VAL   (SCLK_IDLE)
    ) u_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sclk_raw),
        .cond  (sclk_cond),
        .rise  (sclk_rise_flag),
        .fall  (sclk_fall_flag)
    );

    spi_input_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .WAIT_CYCLES (WAIT_CYCLES),
        .RESET_VAL   (CS_IDLE)
    ) u_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (cs_raw),
        .cond  (cs_cond),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_input_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .WAIT_CYCLES (WAIT_CYCLES),
        .RESET_VAL   (MOSI_IDLE)
    ) u_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (mosi_raw),
        .cond  (mosi_cond),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    // SCLK edges count only inside a frame that was already open before this
    // cycle: an SCLK edge landing together with the CS falling edge is dropped.
    assign frame_active = ~cs_cond & ~cs_fall;
    assign sclk_rise    = sclk_rise_flag & frame_active;
    assign sclk_fall    = sclk_fall_flag & frame_active;

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Self-checking bench for spi_input_conditioner: directed scenarios plus
// randomized pad activity compared every cycle against a sample-window model.
module tb_spi_input_conditioner;

    localparam int S  = 2;
    localparam int W  = 3;
    localparam int HL = S + W - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk_raw = 1'b0;
    logic cs_raw = 1'b1;
    logic mosi_raw = 1'b0;
    logic sclk_cond, cs_cond, mosi_cond;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_input_conditioner #(
        .SYNC_STAGES (S),
        .WAIT_CYCLES (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk_raw  (sclk_raw),
        .cs_raw    (cs_raw),
        .mosi_raw  (mosi_raw),
        .sclk_cond (sclk_cond),
        .cs_cond   (cs_cond),
        .mosi_cond (mosi_cond),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: channel 0 = SCLK, 1 = CS, 2 = MOSI. hist[ch][0] is the pad value
    // captured at the most recent edge; a level is accepted once the last W
    // synchronized samples all disagree with the current level.
    logic idle [3] = '{1'b0, 1'b1, 1'b0};
    logic hist [3][HL];
    logic mc   [3];
    logic mr   [3];
    logic mf   [3];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic rawv [3];
        logic alld;
        rawv[0] = sclk_raw;
        rawv[1] = cs_raw;
        rawv[2] = mosi_raw;
        for (int ch = 0; ch < 3; ch++) begin
            if (!rst_n) begin
                for (int i = 0; i < HL; i++) hist[ch][i] = idle[ch];
                mc[ch] = idle[ch];
                mr[ch] = 1'b0;
                mf[ch] = 1'b0;
            end else begin
                alld = 1'b1;
                for (int i = S - 1; i <= S + W - 2; i++)
                    if (hist[ch][i] == mc[ch]) alld = 1'b0;
                mr[ch] = alld & ~mc[ch];
                mf[ch] = alld & mc[ch];
                if (alld) mc[ch] = ~mc[ch];
                for (int i = HL - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
                hist[ch][0] = rawv[ch];
            end
        end
    endtask

    task automatic tick();
        logic gate;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        gate = ~mc[1] & ~mf[1];
        check("sclk_cond", {7'd0, sclk_cond}, {7'd0, mc[0]});
        check("cs_cond",   {7'd0, cs_cond},   {7'd0, mc[1]});
        check("mosi_cond", {7'd0, mosi_cond}, {7'd0, mc[2]});
        check("sclk_rise", {7'd0, sclk_rise}, {7'd0, mr[0] & gate});
        check("sclk_fall", {7'd0, sclk_fall}, {7'd0, mf[0] & gate});
        check("cs_fall",   {7'd0, cs_fall},   {7'd0, mf[1]});
        check("cs_rise",   {7'd0, cs_rise},   {7'd0, mr[1]});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k, got, nrise, ncond_up, ncond_chg;
        logic [7:0] pattern, shreg;
        logic prev;

        for (int ch = 0; ch < 3; ch++) begin
            mc[ch] = idle[ch]; mr[ch] = 1'b0; mf[ch] = 1'b0;
            for (int i = 0; i < HL; i++) hist[ch][i] = idle[ch];
        end

        // Reset, then 20 idle cycles: outputs at idle, no strobes.
        rst_n = 1'b0;
        ticks(3);
        check("reset_cs_cond", {7'd0, cs_cond}, 8'd1);
        rst_n = 1'b1;
        ticks(20);

        // CS fall latency: captured at edge k, visible after edge k+4.
        cs_raw = 1'b0;
        k = cyc + 1;
        got = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cs_fall === 1'b1) begin got = cyc; break; end
        end
        check("cs_fall_latency", 8'(got - k), 8'(S + W - 1));
        ticks(6);

        // Frame 0xA5, MSB first, 8-cycle SCLK phases, MOSI changed on falls.
        pattern = 8'hA5;
        shreg = 8'h00;
        nrise = 0;
        for (int b = 7; b >= 0; b--) begin
            sclk_raw = 1'b0;
            mosi_raw = pattern[b];
            for (int i = 0; i < 8; i++) begin
                tick();
                if (sclk_rise === 1'b1) begin shreg = {shreg[6:0], mosi_cond}; nrise++; end
            end
            sclk_raw = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (sclk_rise === 1'b1) begin shreg = {shreg[6:0], mosi_cond}; nrise++; end
            end
        end
        sclk_raw = 1'b0;
        ticks(10);
        check("frame_rise_count", 8'(nrise), 8'd8);
        check("frame_data", shreg, pattern);

        // CS deasserted: SCLK level follows, edge strobes gated off.
        cs_raw = 1'b1;
        ticks(10);
        nrise = 0;
        ncond_up = 0;
        prev = sclk_cond;
        for (int p = 0; p < 8; p++) begin
            sclk_raw = ~sclk_raw;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (sclk_rise === 1'b1 || sclk_fall === 1'b1) nrise++;
                if (prev === 1'b0 && sclk_cond === 1'b1) ncond_up++;
                prev = sclk_cond;
            end
        end
        check("gated_strobes", 8'(nrise), 8'd0);
        check("gated_cond_rises", 8'(ncond_up), 8'd4);

        // Glitches of 1 and 2 cycles and a 2-on/1-off/2-on burst are filtered.
        sclk_raw = 1'b0;
        ticks(8);
        ncond_chg = 0;
        prev = sclk_cond;
        sclk_raw = 1'b1; tick(); sclk_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (sclk_cond !== prev) ncond_chg++; prev = sclk_cond; end
        sclk_raw = 1'b1; ticks(2); sclk_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (sclk_cond !== prev) ncond_chg++; prev = sclk_cond; end
        sclk_raw = 1'b1; ticks(2); sclk_raw = 1'b0; tick(); sclk_raw = 1'b1; ticks(2); sclk_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (sclk_cond !== prev) ncond_chg++; prev = sclk_cond; end
        check("glitch_filtered", 8'(ncond_chg), 8'd0);
        ncond_up = 0;
        sclk_raw = 1'b1; ticks(3); sclk_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (prev === 1'b0 && sclk_cond === 1'b1) ncond_up++;
            prev = sclk_cond;
        end
        check("clean_pulse_once", 8'(ncond_up), 8'd1);

        // Randomized pad activity with random phase lengths and framing.
        for (int seg = 0; seg < 60; seg++) begin
            sclk_raw = ~sclk_raw;
            mosi_raw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) cs_raw = ~cs_raw;
            ticks(int'($urandom_range(1, 12)));
        end
        sclk_raw = 1'b0;

        // Mid-frame reset: CS returns to idle with no cs_rise, then the still
        // low pad is seen as a fresh frame start with normal latency.
        cs_raw = 1'b0;
        ticks(12);
        check("pre_reset_cs_cond", {7'd0, cs_cond}, 8'd0);
        rst_n = 1'b0;
        tick();
        check("post_reset_cs_cond", {7'd0, cs_cond}, 8'd1);
        check("post_reset_cs_rise", {7'd0, cs_rise}, 8'd0);
        rst_n = 1'b1;
        k = cyc + 1;
        got = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cs_fall === 1'b1) begin got = cyc; break; end
        end
        check("cs_fall_after_reset", 8'(got - k), 8'(S + W - 1));
        ticks(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
